segment_bitmap_engine: RTL and testbench

//  Next-generation TCAM segment engine. Stores one ENTRIES-bit ID bitmap per SDRAM row, row = {fragment index, fragment value}.

---
 rtl/segment_bitmap_engine_if.sv | 45 ++++
 rtl/segment_bitmap_engine.sv | 170 +++++++++++++++++
 tb/tb_segment_bitmap_engine.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_bitmap_engine_if.sv
// Command and Avalon-MM style SDRAM signals of the segment bitmap engine.
// The engine is the slave; the command source and SDRAM controller are the master.
interface segment_bitmap_engine_if #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned FRAGMENTS = 4,
  parameter int unsigned FRAG_BITS = 2,
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned IDWID     = 3
) ();
  localparam int unsigned FRAG_WID = DATA_BITS / FRAGMENTS;
  localparam int unsigned ADDR_WID = FRAG_BITS + FRAG_WID;

  logic                 i_search;
  logic                 i_setting;
  logic                 i_delete;
  logic [DATA_BITS-1:0] i_key;
  logic [FRAGMENTS-1:0] i_setting_mask;
  logic [IDWID-1:0]     i_setting_id;
  logic                 o_ready;
  logic                 o_search_complete;
  logic                 o_setting_complete;
  logic                 o_match;
  logic [IDWID-1:0]     o_match_id;
  logic                 o_sdram_read;
  logic                 o_sdram_write;
  logic [ADDR_WID-1:0]  o_sdram_address;
  logic [ENTRIES-1:0]   o_sdram_writedata;
  logic [ENTRIES-1:0]   i_sdram_readdata;
  logic                 i_sdram_waitrequest;
  logic                 i_sdram_readdatavalid;

  modport slave (
    input  i_search, i_setting, i_delete, i_key, i_setting_mask, i_setting_id,
    input  i_sdram_readdata, i_sdram_waitrequest, i_sdram_readdatavalid,
    output o_ready, o_search_complete, o_setting_complete, o_match, o_match_id,
    output o_sdram_read, o_sdram_write, o_sdram_address, o_sdram_writedata
  );

  modport master (
    output i_search, i_setting, i_delete, i_key, i_setting_mask, i_setting_id,
    output i_sdram_readdata, i_sdram_waitrequest, i_sdram_readdatavalid,
    input  o_ready, o_search_complete, o_setting_complete, o_match, o_match_id,
    input  o_sdram_read, o_sdram_write, o_sdram_address, o_sdram_writedata
  );
endinterface

// File: rtl/segment_bitmap_engine.sv
// TCAM segment engine: one ENTRIES-bit ID bitmap per SDRAM row {fragment index, fragment value}.
// Search ANDs the selected bitmaps; setting/delete read-modify-writes the ID bit in each row.
module segment_bitmap_engine #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned FRAGMENTS = 4,
  parameter int unsigned FRAG_BITS = 2,
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned IDWID     = 3
) (
  input logic                    clk,
  input logic                    reset,
  segment_bitmap_engine_if.slave bus
);
  localparam int unsigned FRAG_WID = DATA_BITS / FRAGMENTS;
  localparam int unsigned ADDR_WID = FRAG_BITS + FRAG_WID;

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StDone} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] key_q, key_d;
  logic [FRAGMENTS-1:0] mask_q, mask_d;
  logic [IDWID-1:0]     id_q, id_d;
  logic                 del_q, del_d;
  logic                 setting_q, setting_d;
  logic [FRAG_BITS-1:0] frag_q, frag_d;
  logic [FRAG_WID-1:0]  row_q, row_d;
  logic [ENTRIES-1:0]   acc_q, acc_d;
  logic [ENTRIES-1:0]   rdata_q, rdata_d;
  logic                 match_q, match_d;
  logic [IDWID-1:0]     match_id_q, match_id_d;

  logic [FRAG_WID-1:0]  key_frag [FRAGMENTS];
  logic [FRAG_WID-1:0]  cur_row;
  logic [ENTRIES-1:0]   id_bit;
  logic [ADDR_WID-1:0]  addr;
  logic                 last_row, last_frag;

  for (genvar f = 0; f < FRAGMENTS; f++) begin : g_frag
    assign key_frag[f] = key_q[f*FRAG_WID +: FRAG_WID];
  end

  function automatic logic [IDWID-1:0] lowest_set(input logic [ENTRIES-1:0] v);
    lowest_set = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDWID'(i);
    end
  endfunction

  // A masked fragment sweeps every row value; otherwise only the key's row is visited.
  assign cur_row   = mask_q[frag_q] ? row_q : key_frag[frag_q];
  assign last_row  = !mask_q[frag_q] || (row_q == '1);
  assign last_frag = (frag_q == FRAG_BITS'(FRAGMENTS - 1));
  assign addr      = {frag_q, cur_row};

  always_comb begin
    id_bit        = '0;
    id_bit[id_q]  = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    mask_d     = mask_q;
    id_d       = id_q;
    del_d      = del_q;
    setting_d  = setting_q;
    frag_d     = frag_q;
    row_d      = row_q;
    acc_d      = acc_q;
    rdata_d    = rdata_q;
    match_d    = match_q;
    match_id_d = match_id_q;
    case (state_q)
      StIdle: begin
        // A setting wins over a simultaneous search; the search is dropped.
        if (bus.i_search || bus.i_setting) begin
          key_d     = bus.i_key;
          mask_d    = bus.i_setting_mask;
          id_d      = bus.i_setting_id;
          del_d     = bus.i_delete;
          setting_d = bus.i_setting;
          frag_d    = '0;
          row_d     = '0;
          acc_d     = '1;
          state_d   = StRdReq;
        end
      end
      StRdReq: begin
        if (!bus.i_sdram_waitrequest) state_d = StRdWait;
      end
      StRdWait: begin
        if (bus.i_sdram_readdatavalid) begin
          if (setting_q) begin
            rdata_d = bus.i_sdram_readdata;
            state_d = StWrReq;
          end else begin
            acc_d = acc_q & bus.i_sdram_readdata;
            if (acc_d == '0 || last_frag) begin
              match_d    = |acc_d;
              match_id_d = lowest_set(acc_d);
              state_d    = StDone;
            end else begin
              frag_d  = frag_q + 1'b1;
              state_d = StRdReq;
            end
          end
        end
      end
      StWrReq: begin
        if (!bus.i_sdram_waitrequest) begin
          if (!last_row) begin
            row_d   = row_q + 1'b1;
            state_d = StRdReq;
          end else begin
            row_d = '0;
            if (last_frag) begin
              state_d = StDone;
            end else begin
              frag_d  = frag_q + 1'b1;
              state_d = StRdReq;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      key_q      <= '0;
      mask_q     <= '0;
      id_q       <= '0;
      del_q      <= 1'b0;
      setting_q  <= 1'b0;
      frag_q     <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      rdata_q    <= '0;
      match_q    <= 1'b0;
      match_id_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      mask_q     <= mask_d;
      id_q       <= id_d;
      del_q      <= del_d;
      setting_q  <= setting_d;
      frag_q     <= frag_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      rdata_q    <= rdata_d;
      match_q    <= match_d;
      match_id_q <= match_id_d;
    end
  end

  assign bus.o_ready            = (state_q == StIdle);
  assign bus.o_search_complete  = (state_q == StDone) && !setting_q;
  assign bus.o_setting_complete = (state_q == StDone) && setting_q;
  assign bus.o_match            = match_q;
  assign bus.o_match_id         = match_id_q;
  assign bus.o_sdram_read       = (state_q == StRdReq);
  assign bus.o_sdram_write      = (state_q == StWrReq);
  assign bus.o_sdram_address    = (state_q == StRdReq || state_q == StWrReq) ? addr : '0;
  assign bus.o_sdram_writedata  = (state_q != StWrReq) ? '0 :
                                  del_q ? (rdata_q & ~id_bit) : (rdata_q | id_bit);
endmodule

// File: tb/tb_segment_bitmap_engine.sv
// Bench for segment_bitmap_engine: SDRAM model, directed vector table, hand-written corner
// sequences and randomized commands against a row-level bitmap reference model.
module tb_segment_bitmap_engine;
  localparam int unsigned DATA_BITS = 16;
  localparam int unsigned FRAGMENTS = 4;
  localparam int unsigned FRAG_BITS = 2;
  localparam int unsigned ENTRIES   = 8;
  localparam int unsigned IDWID     = 3;
  localparam int unsigned FRAG_WID  = DATA_BITS / FRAGMENTS;
  localparam int unsigned ROWS      = 1 << (FRAG_BITS + FRAG_WID);
  localparam int          LIMIT     = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  segment_bitmap_engine_if #(
    .DATA_BITS(DATA_BITS), .FRAGMENTS(FRAGMENTS), .FRAG_BITS(FRAG_BITS),
    .ENTRIES(ENTRIES), .IDWID(IDWID)
  ) bus ();

  segment_bitmap_engine #(
    .DATA_BITS(DATA_BITS), .FRAGMENTS(FRAGMENTS), .FRAG_BITS(FRAG_BITS),
    .ENTRIES(ENTRIES), .IDWID(IDWID)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // SDRAM model
  logic [ENTRIES-1:0] mem [ROWS] = '{default: '0};
  logic [5:0]         rd_addr = '0;
  int                 rd_timer = 0;
  int                 rd_lat = 1;
  int                 n_reads = 0, n_writes = 0, n_scomp = 0, n_tcomp = 0;

  always @(posedge clk) begin
    bus.i_sdram_readdatavalid <= 1'b0;
    if (rd_timer > 0) begin
      rd_timer <= rd_timer - 1;
      if (rd_timer == 1) begin
        bus.i_sdram_readdatavalid <= 1'b1;
        bus.i_sdram_readdata      <= mem[rd_addr];
      end
    end
    if (bus.o_sdram_read && !bus.i_sdram_waitrequest) begin
      n_reads <= n_reads + 1;
      rd_addr <= bus.o_sdram_address;
      if (rd_lat == 1) begin
        bus.i_sdram_readdatavalid <= 1'b1;
        bus.i_sdram_readdata      <= mem[bus.o_sdram_address];
      end else begin
        rd_timer <= rd_lat - 1;
      end
    end
    if (bus.o_sdram_write && !bus.i_sdram_waitrequest) begin
      mem[bus.o_sdram_address] <= bus.o_sdram_writedata;
      n_writes <= n_writes + 1;
    end
    if (bus.o_search_complete)  n_scomp <= n_scomp + 1;
    if (bus.o_setting_complete) n_tcomp <= n_tcomp + 1;
  end

  // Reference model: the expected bitmap image, updated from command semantics only.
  logic [ENTRIES-1:0] ref_mem [ROWS] = '{default: '0};
  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < int'(ROWS); i++) if (mem[i] !== ref_mem[i]) bad++;
    check({name, " rows differing from model"}, bad, 0);
  endtask

  function automatic int frag_of(input logic [15:0] key, input int f);
    return int'(key[f*FRAG_WID +: FRAG_WID]);
  endfunction

  function automatic int ref_setting(input logic [15:0] key, input logic [3:0] mask,
                                     input logic [2:0] id, input bit del);
    int rows;
    rows = 0;
    for (int f = 0; f < int'(FRAGMENTS); f++) begin
      for (int r = 0; r < (1 << FRAG_WID); r++) begin
        if (mask[f] || r == frag_of(key, f)) begin
          ref_mem[f * (1 << FRAG_WID) + r][id] = !del;
          rows++;
        end
      end
    end
    return rows;
  endfunction

  task automatic ref_search(input logic [15:0] key, output int m, output int id,
                            output int reads);
    logic [ENTRIES-1:0] acc;
    bit found;
    acc = '1;
    reads = 0;
    for (int f = 0; f < int'(FRAGMENTS) && acc != 0; f++) begin
      acc &= ref_mem[f * (1 << FRAG_WID) + frag_of(key, f)];
      reads++;
    end
    m = (acc != 0) ? 1 : 0;
    id = 0;
    found = 0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (acc[i] && !found) begin
        id = i;
        found = 1;
      end
    end
  endtask

  // Issue one command and follow it to its completion pulse.
  task automatic run_cmd(input bit s, input bit st, input bit del, input logic [15:0] key,
                         input logic [3:0] mask, input logic [2:0] id, input int stall_first,
                         input bit rand_stall, output int lat, output int dr, output int dw,
                         output int dsc, output int dtc);
    int r0, w0, s0, t0;
    bit pv;
    logic [15:0] prev;
    r0 = n_reads; w0 = n_writes; s0 = n_scomp; t0 = n_tcomp;
    check("ready before command", int'(bus.o_ready), 1);
    bus.i_search = s; bus.i_setting = st; bus.i_delete = del;
    bus.i_key = key; bus.i_setting_mask = mask; bus.i_setting_id = id;
    @(posedge clk); #1;
    bus.i_search = 1'b0; bus.i_setting = 1'b0;
    lat = -1;
    pv = 0;
    prev = '0;
    for (int k = 1; k <= LIMIT; k++) begin
      if (pv) check("request held under waitrequest",
                    int'(prev === {bus.o_sdram_read, bus.o_sdram_write, bus.o_sdram_address,
                                   bus.o_sdram_writedata}), 1);
      if (bus.o_search_complete || bus.o_setting_complete) begin
        lat = k;
        break;
      end
      bus.i_sdram_waitrequest = (k <= stall_first) || (rand_stall && $urandom_range(0, 3) == 0);
      pv = (bus.o_sdram_read || bus.o_sdram_write) && bus.i_sdram_waitrequest;
      prev = {bus.o_sdram_read, bus.o_sdram_write, bus.o_sdram_address, bus.o_sdram_writedata};
      @(posedge clk); #1;
    end
    bus.i_sdram_waitrequest = 1'b0;
    if (lat < 0) check("completion within cycle budget", 0, 1);
    else begin
      @(posedge clk); #1;
      check("ready after complete", int'(bus.o_ready), 1);
    end
    dr = n_reads - r0; dw = n_writes - w0; dsc = n_scomp - s0; dtc = n_tcomp - t0;
  endtask

  typedef struct {
    bit          srch;
    bit          sett;
    bit          del;
    logic [15:0] key;
    logic [3:0]  mask;
    logic [2:0]  id;
    int          exp_match;
    int          exp_id;
    int          exp_reads;
    int          exp_writes;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, dr, dw, dsc, dtc, em, eid, ereads, rows, op, w0;
    logic [15:0] key;
    logic [3:0]  mask;
    logic [2:0]  id;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1234, 4'b0000, 3'd5, 0, 0, 4, 4, 13};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h1234, 4'b0000, 3'd0, 1, 5, 4, 0, 9};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h1204, 4'b0000, 3'd0, 0, 0, 2, 0, 5};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h1234, 4'b0001, 3'd2, 0, 0, 19, 19, 58};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h1234, 4'b0000, 3'd0, 1, 2, 4, 0, 9};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h123F, 4'b0000, 3'd0, 1, 2, 4, 0, 9};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h1234, 4'b0001, 3'd2, 0, 0, 19, 19, 58};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h1234, 4'b0000, 3'd0, 1, 5, 4, 0, 9};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h123F, 4'b0000, 3'd0, 0, 0, 1, 0, 3};

    bus.i_search = 1'b0; bus.i_setting = 1'b0; bus.i_delete = 1'b0;
    bus.i_key = '0; bus.i_setting_mask = '0; bus.i_setting_id = '0;
    bus.i_sdram_waitrequest = 1'b0;

    // Reset held 3 cycles with a search request pending.
    reset = 1'b1;
    bus.i_search = 1'b1;
    bus.i_key = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", int'(bus.o_ready), 1);
    check("reset outputs zero", int'({bus.o_search_complete, bus.o_setting_complete,
          bus.o_match, bus.o_match_id, bus.o_sdram_read, bus.o_sdram_write,
          bus.o_sdram_address, bus.o_sdram_writedata} != 0), 0);
    reset = 1'b0;
    bus.i_search = 1'b0;
    @(posedge clk); #1;
    check("no read from search during reset", n_reads, 0);

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].srch, vecs[i].sett, vecs[i].del, vecs[i].key, vecs[i].mask, vecs[i].id,
              0, 1'b0, lat, dr, dw, dsc, dtc);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d reads", i), dr, vecs[i].exp_reads);
      check($sformatf("vec%0d writes", i), dw, vecs[i].exp_writes);
      if (vecs[i].sett) begin
        rows = ref_setting(vecs[i].key, vecs[i].mask, vecs[i].id, vecs[i].del);
        check($sformatf("vec%0d setting pulses", i), dtc * 10 + dsc, 10);
        check_mem($sformatf("vec%0d", i));
      end else begin
        check($sformatf("vec%0d search pulses", i), dsc * 10 + dtc, 10);
        check($sformatf("vec%0d match", i), int'(bus.o_match), vecs[i].exp_match);
        check($sformatf("vec%0d match_id", i), int'(bus.o_match_id), vecs[i].exp_id);
      end
    end

    // Read stalled by waitrequest for 3 cycles.
    run_cmd(1'b1, 1'b0, 1'b0, 16'h1234, 4'b0000, 3'd0, 3, 1'b0, lat, dr, dw, dsc, dtc);
    check("stall latency", lat, 12);
    check("stall reads", dr, 4);
    check("stall match_id", int'(bus.o_match_id), 5);

    // Search and setting together: setting executes, search dropped.
    run_cmd(1'b1, 1'b1, 1'b0, 16'h5678, 4'b0000, 3'd7, 0, 1'b0, lat, dr, dw, dsc, dtc);
    rows = ref_setting(16'h5678, 4'b0000, 3'd7, 1'b0);
    check("simultaneous writes", dw, rows);
    check("simultaneous pulses", dtc * 10 + dsc, 10);
    check_mem("simultaneous");

    // Reset while waiting for read data of an RMW; the late data must be ignored.
    rd_lat = 2;
    w0 = n_writes;
    bus.i_setting = 1'b1; bus.i_delete = 1'b0; bus.i_key = 16'h0000;
    bus.i_setting_mask = 4'b0000; bus.i_setting_id = 3'd6;
    @(posedge clk); #1;
    bus.i_setting = 1'b0;
    check("mid-RMW read issued", int'(bus.o_sdram_read), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid-RMW reset to idle", int'({bus.o_ready, bus.o_sdram_read, bus.o_sdram_write}),
          4);
    repeat (5) @(posedge clk);
    #1;
    check("mid-RMW no write", n_writes - w0, 0);
    check("mid-RMW still idle", int'(bus.o_ready), 1);
    check_mem("mid-RMW");
    rd_lat = 1;
    run_cmd(1'b1, 1'b0, 1'b0, 16'h1234, 4'b0000, 3'd0, 0, 1'b0, lat, dr, dw, dsc, dtc);
    check("post-reset search match_id", int'(bus.o_match_id), 5);

    // Randomized commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      for (int f = 0; f < int'(FRAGMENTS); f++) begin
        key[f*FRAG_WID +: FRAG_WID] = 4'($urandom_range(0, 3));
        mask[f] = ($urandom_range(0, 5) == 0);
      end
      id = 3'($urandom_range(0, 7));
      if (op == 0) mask = '0;
      rd_lat = $urandom_range(1, 3);
      run_cmd(op == 0, op != 0, op == 2, key, mask, id, 0, 1'b1, lat, dr, dw, dsc, dtc);
      if (op == 0) begin
        ref_search(key, em, eid, ereads);
        check($sformatf("rand%0d search pulses", n), dsc * 10 + dtc, 10);
        check($sformatf("rand%0d match", n), int'(bus.o_match), em);
        check($sformatf("rand%0d match_id", n), int'(bus.o_match_id), eid);
        check($sformatf("rand%0d search reads", n), dr, ereads);
      end else begin
        rows = ref_setting(key, mask, id, op == 2);
        check($sformatf("rand%0d setting pulses", n), dtc * 10 + dsc, 10);
        check($sformatf("rand%0d RMW reads", n), dr, rows);
        check($sformatf("rand%0d RMW writes", n), dw, rows);
        check_mem($sformatf("rand%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
